sprite_anim_renderer: RTL and testbench

- Parametrised successor to the full-screen single-sprite ROM display.
- Places an SPR_W x SPR_H sprite at a runtime position, with optional horizontal flip for fighter facing.
- Steps through FRAMES animation frames packed in an external synchronous sprite ROM.
- Outputs a registered palette index plus an opaque flag to the downstream layer compositor / palette stage.

---
 rtl/sprite_anim_renderer.sv | 152 +++++++++++++++
 tb/tb_sprite_anim_renderer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_anim_renderer.sv
// Sprite renderer: places one SPR_W x SPR_H animated sprite at (pos_x, pos_y),
// optionally mirrored, reading palette indices from an external synchronous ROM.
// Optional feature macro: SPRITE_SCALE_EN adds a scale[1:0] input (1x/2x/4x).
// Pipeline: DrawX/DrawY -> rom_addr (1 cycle) -> ROM (1 cycle) -> pix_idx/pix_on.
module sprite_anim_renderer #(
  parameter int SPR_W       = 64,
  parameter int SPR_H       = 64,
  parameter int FRAMES      = 4,
  parameter int IDX_W       = 4,
  parameter int TRANSP_IDX  = 0,
  parameter int FRAME_TICKS = 6,
  parameter int ADDR_W      = $clog2(SPR_W * SPR_H * FRAMES),
  parameter int FI_W        = (FRAMES > 1) ? $clog2(FRAMES) : 1,
  parameter int TK_W        = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              frame_start,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              flip,
`ifdef SPRITE_SCALE_EN
  input  logic [1:0]        scale,
`endif
  input  logic              anim_start,
  input  logic              anim_loop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pix_idx,
  output logic              pix_on,
  output logic [FI_W-1:0]   frame_idx,
  output logic              anim_done
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StPlay = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [TK_W-1:0]   tick_q, tick_d;
  logic [FI_W-1:0]   frame_d;
  logic              done_d;

  logic [1:0]        sc;
  logic [10:0]       x11, y11, px11, py11;
  logic [10:0]       win_w, win_h;
  logic [10:0]       off_x, off_y, fx;
  logic [10:0]       lx, ly;
  logic              hit;
  logic [ADDR_W-1:0] addr_d;
  logic              hit_d, hit_d2;

  // Stage 1: window test and sprite-local coordinates, 11-bit so no wrap at the edges.
  always_comb begin
`ifdef SPRITE_SCALE_EN
    sc = (scale == 2'd3) ? 2'd2 : scale;
`else
    sc = 2'd0;
`endif
    x11   = {1'b0, DrawX};
    y11   = {1'b0, DrawY};
    px11  = {1'b0, pos_x};
    py11  = {1'b0, pos_y};
    win_w = 11'(SPR_W) << sc;
    win_h = 11'(SPR_H) << sc;
    hit   = blank && (x11 >= px11) && (x11 < px11 + win_w) &&
            (y11 >= py11) && (y11 < py11 + win_h);
    off_x = x11 - px11;
    off_y = y11 - py11;
    // Mirror on the scaled offset so each source texel stays win_w/SPR_W pixels wide.
    fx    = flip ? (win_w - 11'd1 - off_x) : off_x;
    lx    = fx >> sc;
    ly    = off_y >> sc;
    addr_d = ADDR_W'(frame_idx) * ADDR_W'(SPR_W * SPR_H) +
             ADDR_W'(ly) * ADDR_W'(SPR_W) + ADDR_W'(lx);
  end

  // Pixel pipeline: address issue, hit delay to match ROM latency, output register.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr <= '0;
      hit_d    <= 1'b0;
      hit_d2   <= 1'b0;
      pix_idx  <= '0;
      pix_on   <= 1'b0;
    end else begin
      hit_d  <= hit;
      hit_d2 <= hit_d;
      if (hit) rom_addr <= addr_d;
      pix_on  <= hit_d2 && (rom_q != IDX_W'(TRANSP_IDX));
      pix_idx <= hit_d2 ? rom_q : '0;
    end
  end

  // Animation next-state; anim_start overrides everything, including a same-cycle frame_start.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    frame_d = frame_idx;
    done_d  = anim_done;
    if (anim_start) begin
      state_d = StPlay;
      tick_d  = '0;
      frame_d = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        StPlay: begin
          if (frame_start) begin
            if (tick_q == TK_W'(FRAME_TICKS - 1)) begin
              tick_d = '0;
              if (frame_idx == FI_W'(FRAMES - 1)) begin
                if (anim_loop) begin
                  frame_d = '0;
                end else begin
                  done_d  = 1'b1;
                  state_d = StDone;
                end
              end else begin
                frame_d = frame_idx + FI_W'(1);
              end
            end else begin
              tick_d = tick_q + TK_W'(1);
            end
          end
        end
        StDone: done_d = 1'b1;
        StIdle: frame_d = '0;
        default: state_d = StIdle;
      endcase
    end
  end

  // Animation state registers.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      tick_q    <= '0;
      frame_idx <= '0;
      anim_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      frame_idx <= frame_d;
      anim_done <= done_d;
    end
  end

endmodule

// File: tb/tb_sprite_anim_renderer.sv
// Self-checking bench for sprite_anim_renderer (default parameters, 1x scale).
module tb_sprite_anim_renderer;

  localparam int ADDR_W = 14;

  logic              vga_clk = 1'b0;
  logic              reset_n;
  logic [9:0]        DrawX, DrawY, pos_x, pos_y;
  logic              blank, frame_start, flip, anim_start, anim_loop;
  logic [ADDR_W-1:0] rom_addr;
  logic [3:0]        rom_q;
  logic [3:0]        pix_idx;
  logic              pix_on;
  logic [1:0]        frame_idx;
  logic              anim_done;

  logic [3:0] mem [0:16383];

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  sprite_anim_renderer dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .blank       (blank),
    .frame_start (frame_start),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .flip        (flip),
    .anim_start  (anim_start),
    .anim_loop   (anim_loop),
    .rom_addr    (rom_addr),
    .rom_q       (rom_q),
    .pix_idx     (pix_idx),
    .pix_on      (pix_on),
    .frame_idx   (frame_idx),
    .anim_done   (anim_done)
  );

  always #5 vga_clk = ~vga_clk;

  // External synchronous ROM, one cycle read latency.
  always @(posedge vga_clk) rom_q <= mem[rom_addr];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct packed {
    logic        v;
    logic        hit;
    logic [31:0] addr;
  } ent_t;

  ent_t h0, h1, h2;
  int   m_hold;     // last address issued for a hit pixel
  int   m_n;        // frame_starts counted since anim_start
  bit   m_play;
  bit   m_loop;

  function automatic ent_t calc(input int x, input int y, input int px, input int py,
                                input bit fl, input bit b, input int fr);
    ent_t e;
    int ox;
    e.v   = 1'b1;
    e.hit = b && x >= px && x < px + 64 && y >= py && y < py + 64;
    ox    = x - px;
    e.addr = 32'(fr * 4096 + (y - py) * 64 + (fl ? 63 - ox : ox));
    return e;
  endfunction

  function automatic int m_frame(input int n, input bit loop);
    if (loop) return (n / 6) % 4;
    return (n >= 24) ? 3 : n / 6;
  endfunction

  function automatic bit m_done_f(input int n, input bit loop, input bit play);
    return !loop && !play && n >= 24;
  endfunction

  always @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      h0 <= '0; h1 <= '0; h2 <= '0;
      m_hold <= 0; m_n <= 0; m_play <= 1'b0; m_loop <= 1'b0;
    end else begin
      h0 <= calc(DrawX, DrawY, pos_x, pos_y, flip, blank, m_frame(m_n, m_loop));
      h1 <= h0;
      h2 <= h1;
      if (calc(DrawX, DrawY, pos_x, pos_y, flip, blank, m_frame(m_n, m_loop)).hit)
        m_hold <= calc(DrawX, DrawY, pos_x, pos_y, flip, blank, m_frame(m_n, m_loop)).addr;
      if (anim_start) begin
        m_n <= 0; m_play <= 1'b1; m_loop <= anim_loop;
      end else if (m_play && frame_start) begin
        m_n <= m_n + 1;
        if (!m_loop && m_n + 1 >= 24) m_play <= 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge vga_clk) begin
    if (chk_en) begin
      chk("rom_addr", int'(rom_addr), m_hold);
      chk("pix_on", int'(pix_on),
          int'(h2.v && h2.hit && mem[h2.addr[13:0]] != 4'd0));
      chk("pix_idx", int'(pix_idx), (h2.v && h2.hit) ? int'(mem[h2.addr[13:0]]) : 0);
      chk("frame_idx", int'(frame_idx), m_frame(m_n, m_loop));
      chk("anim_done", int'(anim_done), int'(m_done_f(m_n, m_loop, m_play)));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(); @(negedge vga_clk); endtask

  task automatic px(input int x, input int y, input bit b);
    DrawX = 10'(x); DrawY = 10'(y); blank = b;
    cyc();
  endtask

  task automatic fs();
    frame_start = 1'b1; cyc(); frame_start = 1'b0; cyc();
  endtask

  task automatic start(input bit loop);
    anim_loop = loop; anim_start = 1'b1; cyc(); anim_start = 1'b0;
  endtask

  int exp_f [6] = '{0, 1, 2, 3, 3, 3};
  int chk_k [6] = '{5, 6, 12, 18, 23, 24};

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
    mem[0] = 4'd9; mem[1] = 4'd0; mem[2] = 4'd5;
    reset_n = 1'b0; DrawX = '0; DrawY = '0; blank = 1'b0; frame_start = 1'b0;
    pos_x = '0; pos_y = '0; flip = 1'b0; anim_start = 1'b0; anim_loop = 1'b0;
    cyc();
    #1 chk_en = 1'b1;
    chk("reset_rom_addr", int'(rom_addr), 0);
    chk("reset_pix_on", int'(pix_on), 0);
    chk("reset_frame", int'(frame_idx), 0);
    chk("reset_done", int'(anim_done), 0);
    cyc();
    reset_n = 1'b1;
    cyc();

    // Basic hit, transparent word, opaque word.
    pos_x = 10'd100; pos_y = 10'd50;
    px(100, 50, 1);
    chk("t1_addr0", int'(rom_addr), 0);
    px(101, 50, 1);
    chk("t1_addr1", int'(rom_addr), 1);
    px(102, 50, 1);
    chk("t1_pix_on", int'(pix_on), 1);
    chk("t1_pix_idx", int'(pix_idx), 9);
    px(0, 0, 0);
    chk("t4_transp_on", int'(pix_on), 0);
    px(0, 0, 0);
    chk("t4_word5_on", int'(pix_on), 1);
    chk("t4_word5_idx", int'(pix_idx), 5);

    // Right-edge clipping and blanking.
    pos_x = 10'd600; pos_y = 10'd0;
    px(639, 0, 1);
    chk("t2_clip_addr", int'(rom_addr), 39);
    px(599, 0, 1);
    px(610, 3, 0);
    chk("t2_hold_addr", int'(rom_addr), 39);
    px(0, 0, 0);
    chk("t2_left_off", int'(pix_on), 0);
    px(0, 0, 0);
    chk("t2_blank_off", int'(pix_on), 0);

    // Flip.
    pos_x = 10'd0; pos_y = 10'd0; flip = 1'b1;
    px(0, 1, 1);
    chk("t3_flip_addr", int'(rom_addr), 127);
    flip = 1'b0;
    px(0, 1, 1);
    chk("t3_noflip_addr", int'(rom_addr), 64);
    blank = 1'b0;

    // Non-looping animation.
    start(1'b0);
    for (int k = 1; k <= 24; k++) begin
      fs();
      for (int j = 0; j < 6; j++)
        if (chk_k[j] == k) chk($sformatf("t5_frame_k%0d", k), int'(frame_idx), exp_f[j]);
      if (k == 23) chk("t5_done_k23", int'(anim_done), 0);
    end
    chk("t5_done", int'(anim_done), 1);
    fs();
    chk("t5_hold3", int'(frame_idx), 3);

    // Looping animation.
    start(1'b1);
    for (int k = 1; k <= 24; k++) fs();
    chk("t5_loop_frame", int'(frame_idx), 0);
    chk("t5_loop_done", int'(anim_done), 0);

    // Frame-2 addressing, then anim_start colliding with frame_start.
    start(1'b0);
    for (int k = 0; k < 12; k++) fs();
    chk("t5_frame2", int'(frame_idx), 2);
    px(0, 0, 1);
    chk("t5_f2_addr", int'(rom_addr), 8192);
    blank = 1'b0;
    anim_start = 1'b1; frame_start = 1'b1; cyc();
    anim_start = 1'b0; frame_start = 1'b0; cyc();
    chk("t6_restart", int'(frame_idx), 0);
    for (int k = 0; k < 5; k++) fs();
    chk("t6_tick_cleared", int'(frame_idx), 0);
    fs();
    chk("t6_next_frame", int'(frame_idx), 1);

    // Asynchronous reset in the middle of a hit run.
    pos_x = 10'd100; pos_y = 10'd50;
    for (int i = 0; i < 6; i++) px(100 + i, 52, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_pix_on", int'(pix_on), 0);
    chk("t6_rst_pix_idx", int'(pix_idx), 0);
    chk("t6_rst_addr", int'(rom_addr), 0);
    chk("t6_rst_frame", int'(frame_idx), 0);
    chk("t6_rst_done", int'(anim_done), 0);
    cyc(); cyc();
    reset_n = 1'b1;

    // Randomised phase; anim_loop only changes together with anim_start.
    for (int c = 0; c < 4000; c++) begin
      if (c % 64 == 0) begin
        pos_x = 10'($urandom_range(0, 639));
        pos_y = 10'($urandom_range(0, 479));
        flip  = 1'($urandom);
      end
      if ($urandom_range(0, 199) == 0) begin
        anim_loop = 1'($urandom); anim_start = 1'b1;
      end else begin
        anim_start = 1'b0;
      end
      frame_start = ($urandom_range(0, 5) == 0);
      DrawX = 10'(((int'(pos_x) + int'($urandom_range(0, 72)) - 4) % 640 + 640) % 640);
      DrawY = 10'(((int'(pos_y) + int'($urandom_range(0, 72)) - 4) % 480 + 480) % 480);
      blank = ($urandom_range(0, 7) != 0);
      cyc();
    end
    anim_start = 1'b0; frame_start = 1'b0; blank = 1'b0;
    cyc(); cyc(); cyc();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
